fft_dif_stage_ctrl: RTL and testbench
=====================================

FFT_DIF_STAGE_CTRL -- requirements
Module: fft_dif_stage_ctrl

Interface
REQ-001 SHALL have parameter N_LOG2, default 8, meaning log2 of FFT points (N=256).
REQ-002 SHALL have parameter LAT, default 2, meaning read-issue-to-write latency in cycles (1 RAM read + 1 butterfly Y1 register).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to run a full transform.
REQ-006 stall  in  1  when 1, suspends address issue and output sweep.
REQ-007 busy  out  1  high from the cycle after accepted start until done.
REQ-008 done  out  1  one-cycle pulse at completion.
REQ-009 stage  out  N_LOG2 bits  current stage index, 0..N_LOG2-1.
REQ-010 rd_en  out  1  butterfly operand read strobe.
REQ-011 rd_addr0 / rd_addr1  out  N_LOG2 each  upper/lower operand addresses.
REQ-012 tw_addr  out  N_LOG2-1  twiddle ROM index feeding sin/cos.
REQ-013 wr_en  out  1  result write strobe.
REQ-014 wr_addr0 / wr_addr1  out  N_LOG2 each  Y0/Y1 write addresses.
REQ-015 out_valid / out_addr  out  1 / N_LOG2  bit-reversed readout (see Configuration).

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DRAIN -> (RUN | OUT | FIN) -> IDLE.
REQ-017 IDLE: start=1 at an edge SHALL move to RUN, stage=0, butterfly counter b=0; start in any other state SHALL be ignored.
REQ-018 RUN, stall=0: rd_en=1 and b increments; stall=1: rd_en=0, b, stage frozen.
REQ-019 Address rule for stage s, span=N>>(s+1), pos=b mod span, grp=b/span: rd_addr0=2*span*grp+pos, rd_addr1=rd_addr0+span, tw_addr=pos<<s.
REQ-020 After issuing b=N/2-1, SHALL enter DRAIN for exactly LAT cycles with rd_en=0, regardless of stall.
REQ-021 DRAIN end: stage<N_LOG2-1 -> stage+1, b=0, RUN; else -> OUT (macro defined) or FIN.
REQ-022 wr_en, wr_addr0, wr_addr1 SHALL equal rd_en, rd_addr0, rd_addr1 delayed exactly LAT cycles via a shift register that never stalls.
REQ-023 FIN SHALL last one cycle with done=1, busy=0 next cycle, return to IDLE.
REQ-024 busy SHALL be 1 in RUN, DRAIN, OUT; 0 in IDLE and FIN.
REQ-025 Unstalled run with LAT=2: start at cycle 0, stage k reads in cycles 1+130k..128+130k, done at cycle 1041.
REQ-026 No read of stage s+1 SHALL occur before the final write of stage s (guaranteed by REQ-020).

Reset
REQ-027 rst=0 SHALL immediately force IDLE, b=0, stage=0, clear delay line; busy, done, rd_en, wr_en, out_valid=0; all addresses 0.
REQ-028 Reset mid-transform SHALL abort with no wr_en pulse after release; next start SHALL begin from stage 0.

Configuration
REQ-029 Macro FFT_BITREV_OUT_EN: when defined, OUT state SHALL sweep j=0..N-1, one per unstalled cycle, out_valid=1, out_addr=bit-reverse of j over N_LOG2 bits, then FIN; unstalled done at cycle 1297.
REQ-030 When undefined, OUT state, out_valid and out_addr logic SHALL be absent; out_valid, out_addr tied 0; DRAIN of last stage goes to FIN.

Verification
REQ-031 Start, no stall: stage 0, b=0 -> rd_addr0=0, rd_addr1=128, tw_addr=0; b=1 -> 1, 129, 1; wr_en for b=0 at cycle 3.
REQ-032 Stage 1, b=64 -> rd_addr0=128, rd_addr1=192, tw_addr=0; stage 7, b=5 -> 10, 11, 0.
REQ-033 Full run, no stall -> exactly 1024 rd_en and 1024 wr_en pulses, done single pulse at cycle 1041 (1297 with macro).
REQ-034 stall=1 for 10 cycles mid stage 3 -> addresses held, rd_en=0, pending writes still complete, done delayed by exactly 10 cycles.
REQ-035 start pulsed while busy, then rst=0 at cycle 500 -> start ignored, all outputs 0 at once, no wr_en after release, new start runs full transform from stage 0.
REQ-036 Macro defined: out_addr sequence 0, 128, 64, 192, 32 ... 255 with out_valid=1 for 256 cycles before done.

Source files
------------

// File: rtl/fft_dif_stage_ctrl.sv
// Address/control sequencer for an in-place radix-2 DIF FFT: issues butterfly reads, delays them into writes.
// Optional bit-reversed readout sweep is enabled with `define FFT_BITREV_OUT_EN.
module fft_dif_stage_ctrl #(
    parameter int N_LOG2 = 8,
    parameter int LAT    = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stall,
    output logic              o_busy,
    output logic              o_done,
    output logic [N_LOG2-1:0] o_stage,
    output logic              o_rd_en,
    output logic [N_LOG2-1:0] o_rd_addr0,
    output logic [N_LOG2-1:0] o_rd_addr1,
    output logic [N_LOG2-2:0] o_tw_addr,
    output logic              o_wr_en,
    output logic [N_LOG2-1:0] o_wr_addr0,
    output logic [N_LOG2-1:0] o_wr_addr1,
    output logic              o_out_valid,
    output logic [N_LOG2-1:0] o_out_addr
);

    localparam int                DW         = (LAT < 2) ? 1 : $clog2(LAT);
    localparam logic [DW-1:0]     DRAIN_LAST = DW'(LAT - 1);
    localparam logic [DW-1:0]     ONE_D      = 1;
    localparam logic [N_LOG2-1:0] LAST_STAGE = N_LOG2'(N_LOG2 - 1);
    localparam logic [N_LOG2-1:0] ONE_N      = 1;
    localparam logic [N_LOG2-2:0] B_LAST     = '1;
    localparam logic [N_LOG2-2:0] ONE_B      = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FIN
`ifdef FFT_BITREV_OUT_EN
        , S_OUT
`endif
    } state_t;

    state_t              r_state;
    logic [N_LOG2-2:0]   r_b;
    logic [N_LOG2-1:0]   r_stage;
    logic [DW-1:0]       r_drain;
    logic                r_busy;
    logic                r_done;
`ifdef FFT_BITREV_OUT_EN
    logic [N_LOG2-1:0]   r_j;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_b     <= '0;
            r_stage <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef FFT_BITREV_OUT_EN
            r_j     <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_RUN;
                        r_b     <= '0;
                        r_stage <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!i_stall) begin
                        if (r_b == B_LAST) begin
                            r_state <= S_DRAIN;
                            r_drain <= '0;
                        end
                        r_b <= r_b + ONE_B;
                    end
                end
                // Drain ignores stall so the last writes of a stage land before the next stage reads.
                S_DRAIN: begin
                    if (r_drain == DRAIN_LAST) begin
                        if (r_stage != LAST_STAGE) begin
                            r_stage <= r_stage + ONE_N;
                            r_b     <= '0;
                            r_state <= S_RUN;
                        end else begin
`ifdef FFT_BITREV_OUT_EN
                            r_state <= S_OUT;
                            r_j     <= '0;
`else
                            r_state <= S_FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
`endif
                        end
                    end else begin
                        r_drain <= r_drain + ONE_D;
                    end
                end
`ifdef FFT_BITREV_OUT_EN
                S_OUT: begin
                    if (!i_stall) begin
                        if (r_j == '1) begin
                            r_state <= S_FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                        r_j <= r_j + ONE_N;
                    end
                end
`endif
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_stage <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Operand addresses: insert a 0/1 bit at position log2(span) of the butterfly index.
    logic                w_run;
    logic [N_LOG2-1:0]   w_b_ext;
    logic [N_LOG2-1:0]   w_shift;
    logic [N_LOG2-1:0]   w_span;
    logic [N_LOG2-1:0]   w_mask;
    logic [N_LOG2-1:0]   w_pos;
    logic [N_LOG2-1:0]   w_hi;
    logic [N_LOG2-1:0]   w_a0;

    assign w_run   = (r_state == S_RUN);
    assign w_b_ext = {1'b0, r_b};
    assign w_shift = LAST_STAGE - r_stage;
    assign w_span  = ONE_N << w_shift;
    assign w_mask  = w_span - ONE_N;
    assign w_pos   = w_b_ext & w_mask;
    assign w_hi    = w_b_ext & ~w_mask;
    assign w_a0    = (w_hi << 1) | w_pos;

    assign o_rd_en    = w_run & ~i_stall;
    assign o_rd_addr0 = w_run ? w_a0 : '0;
    assign o_rd_addr1 = w_run ? (w_a0 | w_span) : '0;
    assign o_tw_addr  = w_run ? (w_pos[N_LOG2-2:0] << r_stage) : '0;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_stage    = r_stage;

    logic                r_dl_en [LAT];
    logic [N_LOG2-1:0]   r_dl_a0 [LAT];
    logic [N_LOG2-1:0]   r_dl_a1 [LAT];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                r_dl_en[k] <= 1'b0;
                r_dl_a0[k] <= '0;
                r_dl_a1[k] <= '0;
            end
        end else begin
            r_dl_en[0] <= o_rd_en;
            r_dl_a0[0] <= o_rd_addr0;
            r_dl_a1[0] <= o_rd_addr1;
            for (int k = 1; k < LAT; k++) begin
                r_dl_en[k] <= r_dl_en[k-1];
                r_dl_a0[k] <= r_dl_a0[k-1];
                r_dl_a1[k] <= r_dl_a1[k-1];
            end
        end
    end

    assign o_wr_en    = r_dl_en[LAT-1];
    assign o_wr_addr0 = r_dl_a0[LAT-1];
    assign o_wr_addr1 = r_dl_a1[LAT-1];

`ifdef FFT_BITREV_OUT_EN
    logic [N_LOG2-1:0] w_rev;
    always_comb begin
        w_rev = '0;
        for (int k = 0; k < N_LOG2; k++) begin
            w_rev[k] = r_j[N_LOG2-1-k];
        end
    end
    assign o_out_valid = (r_state == S_OUT) & ~i_stall;
    assign o_out_addr  = (r_state == S_OUT) ? w_rev : '0;
`else
    assign o_out_valid = 1'b0;
    assign o_out_addr  = '0;
`endif

endmodule

// File: tb/tb_fft_dif_stage_ctrl.sv
// Scoreboard bench for fft_dif_stage_ctrl: expected read/write/readout sequences queued per run.
`timescale 1ns/1ps
module tb_fft_dif_stage_ctrl;

    localparam int N_LOG2 = 8;
    localparam int N      = 256;
    localparam int LAT    = 2;
`ifdef FFT_BITREV_OUT_EN
    localparam int T_DONE = 1297;
`else
    localparam int T_DONE = 1041;
`endif

    logic              clk = 1'b0;
    logic              i_rst_n;
    logic              i_start;
    logic              i_stall;
    logic              o_busy;
    logic              o_done;
    logic [N_LOG2-1:0] o_stage;
    logic              o_rd_en;
    logic [N_LOG2-1:0] o_rd_addr0;
    logic [N_LOG2-1:0] o_rd_addr1;
    logic [N_LOG2-2:0] o_tw_addr;
    logic              o_wr_en;
    logic [N_LOG2-1:0] o_wr_addr0;
    logic [N_LOG2-1:0] o_wr_addr1;
    logic              o_out_valid;
    logic [N_LOG2-1:0] o_out_addr;

    always #5 clk = ~clk;

    fft_dif_stage_ctrl #(.N_LOG2(N_LOG2), .LAT(LAT)) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_stall     (i_stall),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_stage     (o_stage),
        .o_rd_en     (o_rd_en),
        .o_rd_addr0  (o_rd_addr0),
        .o_rd_addr1  (o_rd_addr1),
        .o_tw_addr   (o_tw_addr),
        .o_wr_en     (o_wr_en),
        .o_wr_addr0  (o_wr_addr0),
        .o_wr_addr1  (o_wr_addr1),
        .o_out_valid (o_out_valid),
        .o_out_addr  (o_out_addr)
    );

    typedef struct {
        int a0;
        int a1;
        int tw;
    } op_t;

    op_t q_rd[$];
    op_t q_wr[$];
    int  q_out[$];

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    int  t0      = 0;
    bit  mon_en  = 1'b0;
    int  g_sa    = -1;
    bit  g_fixed = 1'b0;
    int  rd_cnt, wr_cnt, out_cnt, done_cnt, done_rel;
    int  m_rel;
    op_t m_e;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_expected();
        op_t e;
        int  span, pos, grp, r;
        q_rd.delete();
        q_wr.delete();
        q_out.delete();
        for (int s = 0; s < N_LOG2; s++) begin
            span = N >> (s + 1);
            for (int b = 0; b < N / 2; b++) begin
                pos  = b % span;
                grp  = b / span;
                e.a0 = 2 * span * grp + pos;
                e.a1 = e.a0 + span;
                e.tw = pos << s;
                q_rd.push_back(e);
                q_wr.push_back(e);
            end
        end
        for (int j = 0; j < N; j++) begin
            r = 0;
            for (int k = 0; k < N_LOG2; k++)
                if (((j >> k) & 1) == 1) r = r | (1 << (N_LOG2 - 1 - k));
            q_out.push_back(r);
        end
        rd_cnt   = 0;
        wr_cnt   = 0;
        out_cnt  = 0;
        done_cnt = 0;
        done_rel = -1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},      o_busy,      0);
        chk({tag, "_done"},      o_done,      0);
        chk({tag, "_stage"},     o_stage,     0);
        chk({tag, "_rd_en"},     o_rd_en,     0);
        chk({tag, "_rd_addr0"},  o_rd_addr0,  0);
        chk({tag, "_rd_addr1"},  o_rd_addr1,  0);
        chk({tag, "_tw_addr"},   o_tw_addr,   0);
        chk({tag, "_wr_en"},     o_wr_en,     0);
        chk({tag, "_wr_addr0"},  o_wr_addr0,  0);
        chk({tag, "_wr_addr1"},  o_wr_addr1,  0);
        chk({tag, "_out_valid"}, o_out_valid, 0);
        chk({tag, "_out_addr"},  o_out_addr,  0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            m_rel = cyc - t0;
            if (o_rd_en) begin
                rd_cnt++;
                chk("rd_q_nonempty", (q_rd.size() > 0), 1);
                if (q_rd.size() > 0) begin
                    m_e = q_rd.pop_front();
                    chk("rd_addr0", o_rd_addr0, m_e.a0);
                    chk("rd_addr1", o_rd_addr1, m_e.a1);
                    chk("tw_addr",  o_tw_addr,  m_e.tw);
                end
            end
            if (o_wr_en) begin
                wr_cnt++;
                chk("wr_q_nonempty", (q_wr.size() > 0), 1);
                if (q_wr.size() > 0) begin
                    m_e = q_wr.pop_front();
                    chk("wr_addr0", o_wr_addr0, m_e.a0);
                    chk("wr_addr1", o_wr_addr1, m_e.a1);
                end
            end
            if (o_out_valid) begin
                out_cnt++;
                chk("out_q_nonempty", (q_out.size() > 0), 1);
                if (q_out.size() > 0) chk("out_addr", o_out_addr, q_out.pop_front());
            end
            if (o_done) begin
                done_cnt++;
                if (done_rel < 0) done_rel = m_rel;
                chk("busy_in_fin", o_busy, 0);
            end
            if (g_fixed) begin
                if (m_rel == 1) begin
                    chk("first_busy", o_busy, 1);
                    chk("first_rd_en", o_rd_en, 1);
                    chk("s0b0_addr0", o_rd_addr0, 0);
                    chk("s0b0_addr1", o_rd_addr1, 128);
                    chk("s0b0_tw", o_tw_addr, 0);
                end
                if (m_rel == 2) begin
                    chk("s0b1_addr0", o_rd_addr0, 1);
                    chk("s0b1_addr1", o_rd_addr1, 129);
                    chk("s0b1_tw", o_tw_addr, 1);
                    chk("wr_latency_early", o_wr_en, 0);
                end
                if (m_rel == 3) begin
                    chk("wr_latency", o_wr_en, 1);
                    chk("wr0_addr1", o_wr_addr1, 128);
                end
                if (m_rel == 129) chk("drain_rd_en", o_rd_en, 0);
                if (m_rel == 131) chk("stage1_start", o_stage, 1);
                if (m_rel == 195) begin
                    chk("s1b64_addr0", o_rd_addr0, 128);
                    chk("s1b64_addr1", o_rd_addr1, 192);
                    chk("s1b64_tw", o_tw_addr, 0);
                end
                if (m_rel == 916) begin
                    chk("s7_stage", o_stage, 7);
                    chk("s7b5_addr0", o_rd_addr0, 10);
                    chk("s7b5_addr1", o_rd_addr1, 11);
                    chk("s7b5_tw", o_tw_addr, 0);
                end
            end
            if (g_sa >= 0) begin
                if (m_rel == g_sa || m_rel == g_sa + 1) chk("wr_during_stall", o_wr_en, 1);
                if (m_rel == g_sa + 2) chk("wr_after_pending", o_wr_en, 0);
                if (m_rel == g_sa + 5) begin
                    chk("rd_en_stalled", o_rd_en, 0);
                    chk("stage_stalled", o_stage, 3);
                    if (q_rd.size() > 0) begin
                        chk("stall_hold_addr0", o_rd_addr0, q_rd[0].a0);
                        chk("stall_hold_addr1", o_rd_addr1, q_rd[0].a1);
                    end
                end
            end
        end
    end

    task automatic run_full(input int sa, input int exp_done);
        int rel;
        load_expected();
        g_sa    = sa;
        g_fixed = (sa < 0);
        t0      = cyc;
        mon_en  = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
            rel     = cyc - t0;
            i_stall = (sa >= 0 && rel >= sa && rel < sa + 10);
            tick();
        end
        i_stall = 1'b0;
        repeat (3) tick();
        mon_en = 1'b0;
        chk("done_cycle",  done_rel, exp_done);
        chk("done_pulses", done_cnt, 1);
        chk("rd_pulses",   rd_cnt,   1024);
        chk("wr_pulses",   wr_cnt,   1024);
        chk("rd_q_left",   q_rd.size(), 0);
        chk("wr_q_left",   q_wr.size(), 0);
`ifdef FFT_BITREV_OUT_EN
        chk("out_pulses",  out_cnt,  256);
        chk("out_q_left",  q_out.size(), 0);
`else
        chk("out_pulses",  out_cnt,  0);
`endif
        chk("busy_idle",   o_busy, 0);
        chk("done_idle",   o_done, 0);
        chk("stage_idle",  o_stage, 0);
    endtask

    initial begin
        int wr_seen;
        int busy_seen;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        i_rst_n = 1'b1;
        repeat (2) tick();

        run_full(-1, T_DONE);
        repeat (2) tick();
        run_full(450, T_DONE + 10);
        repeat (2) tick();

        // Aborted transform: a second start mid-run, then reset at cycle 500
        load_expected();
        g_sa    = -1;
        g_fixed = 1'b0;
        t0      = cyc;
        mon_en  = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        while (cyc - t0 < 500) begin
            i_start = ((cyc - t0) == 200);
            if ((cyc - t0) == 202) begin
                chk("start_ignored_busy",  o_busy,  1);
                chk("start_ignored_stage", o_stage, 1);
            end
            tick();
        end
        i_start = 1'b0;
        mon_en  = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (3) tick();
        i_rst_n   = 1'b1;
        wr_seen   = 0;
        busy_seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (o_wr_en) wr_seen++;
            if (o_busy) busy_seen++;
        end
        chk("wr_after_release",   wr_seen,   0);
        chk("busy_after_release", busy_seen, 0);

        run_full(-1, T_DONE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
